// File: rtl/axi_ram_rd_arb.sv
// Two-requester AXI4 read arbiter: one burst at a time, round-robin on ties.
// Define AXI_RAM_RD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module axi_ram_rd_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*ID_WIDTH-1:0]   s_axi_arid,
  input  logic [2*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [15:0]             s_axi_arlen,
  input  logic [5:0]              s_axi_arsize,
  input  logic [3:0]              s_axi_arburst,
  input  logic [1:0]              s_axi_arvalid,
  output logic [1:0]              s_axi_arready,
  output logic [2*ID_WIDTH-1:0]   s_axi_rid,
  output logic [2*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [3:0]              s_axi_rresp,
  output logic [1:0]              s_axi_rlast,
  output logic [1:0]              s_axi_rvalid,
  input  logic [1:0]              s_axi_rready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    grant_q;
  logic                    ptr_q;
  logic                    any_req_s;
  logic                    win_s;
  logic [1:0]              arready_s;
  logic [1:0]              rvalid_s;
  logic                    m_rready_s;
  logic                    last_hs_s;
  logic [ID_WIDTH-1:0]     win_id_s;
  logic [ADDR_WIDTH-1:0]   win_addr_s;
  logic [7:0]              win_len_s;
  logic [2:0]              win_size_s;
  logic [1:0]              win_burst_s;

  // Winner selection; in fixed-priority builds ptr_q stays 0 so ties go to requester 0
  always_comb begin
    any_req_s = |s_axi_arvalid;
    if (&s_axi_arvalid) begin
      win_s = ptr_q;
    end else begin
      win_s = s_axi_arvalid[1];
    end
    if (win_s) begin
      win_id_s    = s_axi_arid[ID_WIDTH +: ID_WIDTH];
      win_addr_s  = s_axi_araddr[ADDR_WIDTH +: ADDR_WIDTH];
      win_len_s   = s_axi_arlen[15:8];
      win_size_s  = s_axi_arsize[5:3];
      win_burst_s = s_axi_arburst[3:2];
    end else begin
      win_id_s    = s_axi_arid[ID_WIDTH-1:0];
      win_addr_s  = s_axi_araddr[ADDR_WIDTH-1:0];
      win_len_s   = s_axi_arlen[7:0];
      win_size_s  = s_axi_arsize[2:0];
      win_burst_s = s_axi_arburst[1:0];
    end
  end

  // Handshake steering; gated by rst so outputs drop the moment reset asserts
  always_comb begin
    arready_s  = 2'b00;
    rvalid_s   = 2'b00;
    m_rready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst && any_req_s) begin
          arready_s = win_s ? 2'b10 : 2'b01;
        end else begin
          arready_s = 2'b00;
        end
      end
      ST_DATA: begin
        if (rst) begin
          rvalid_s   = grant_q ? {m_axi_rvalid, 1'b0} : {1'b0, m_axi_rvalid};
          m_rready_s = s_axi_rready[grant_q];
        end else begin
          rvalid_s   = 2'b00;
          m_rready_s = 1'b0;
        end
      end
      default: begin
        arready_s  = 2'b00;
        rvalid_s   = 2'b00;
        m_rready_s = 1'b0;
      end
    endcase
  end

  assign last_hs_s     = m_axi_rvalid & m_rready_s & m_axi_rlast;
  assign s_axi_arready = arready_s;
  assign s_axi_rvalid  = rvalid_s;
  assign m_axi_rready  = m_rready_s;
  assign s_axi_rid     = {2{m_axi_rid}};
  assign s_axi_rdata   = {2{m_axi_rdata}};
  assign s_axi_rresp   = {2{m_axi_rresp}};
  assign s_axi_rlast   = {2{m_axi_rlast}};

  // Arbitration FSM with registered AR outputs toward the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      ptr_q         <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= 8'd0;
      m_axi_arsize  <= 3'd0;
      m_axi_arburst <= 2'd0;
      m_axi_arvalid <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_s) begin
            m_axi_arid    <= win_id_s;
            m_axi_araddr  <= win_addr_s;
            m_axi_arlen   <= win_len_s;
            m_axi_arsize  <= win_size_s;
            m_axi_arburst <= win_burst_s;
            m_axi_arvalid <= 1'b1;
            grant_q       <= win_s;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state_q       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (last_hs_s) begin
`ifdef AXI_RAM_RD_ARB_FIXED_PRIO_EN
            ptr_q <= 1'b0;
`else
            ptr_q <= ~grant_q;
`endif
            state_q <= ST_IDLE;
          end
        end
        default: begin
          m_axi_arvalid <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_ram_rd_arb.md
Name: axi_ram_rd_arb

Overview:
Two-requester AXI4 read-channel arbiter placed in front of the AXI RAM's AR/R ports, so two masters (e.g. DMA and CPU) share one read port.
- Grants one burst at a time, round-robin.
- Forwards the AR beat with a one-cycle registered delay.
- Routes R beats back to the granted master until the rlast handshake.
- Write channels are not handled; they connect to the RAM directly.

Parameters:
DATA_WIDTH, 32, R data width in bits
ADDR_WIDTH, 16, AR address width in bits
ID_WIDTH, 8, AXI ID width; IDs pass through unchanged

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset)
s_axi_arid  in  2*ID_WIDTH  per-requester ARID, requester i at [i*ID_WIDTH +: ID_WIDTH]
s_axi_araddr  in  2*ADDR_WIDTH  per-requester ARADDR
s_axi_arlen  in  2*8  per-requester ARLEN
s_axi_arsize  in  2*3  per-requester ARSIZE
s_axi_arburst  in  2*2  per-requester ARBURST
s_axi_arvalid  in  2  per-requester ARVALID
s_axi_arready  out  2  per-requester ARREADY
s_axi_rid  out  2*ID_WIDTH  RID, replicated to both slots
s_axi_rdata  out  2*DATA_WIDTH  RDATA, replicated to both slots
s_axi_rresp  out  2*2  RRESP, replicated to both slots
s_axi_rlast  out  2  RLAST, replicated to both slots
s_axi_rvalid  out  2  RVALID, asserted only on the granted slot
s_axi_rready  in  2  per-requester RREADY
m_axi_arid  out  ID_WIDTH  to RAM, registered
m_axi_araddr  out  ADDR_WIDTH  to RAM, registered
m_axi_arlen  out  8  to RAM, registered
m_axi_arsize  out  3  to RAM, registered
m_axi_arburst  out  2  to RAM, registered
m_axi_arvalid  out  1  to RAM, registered
m_axi_arready  in  1  from RAM
m_axi_rid  in  ID_WIDTH  from RAM
m_axi_rdata  in  DATA_WIDTH  from RAM
m_axi_rresp  in  2  from RAM
m_axi_rlast  in  1  from RAM
m_axi_rvalid  in  1  from RAM
m_axi_rready  out  1  to RAM

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state = IDLE, grant = 0, priority pointer = requester 0;
  - m_axi_arvalid = 0 and all m_axi_ar* payload registers = 0;
  - s_axi_arready = 0, s_axi_rvalid = 0, m_axi_rready = 0.
  - These outputs go to 0 immediately on reset assertion, not at the next edge.
- State machine: IDLE -> ISSUE -> DATA -> IDLE.
- IDLE:
  - If any s_axi_arvalid is high, pick a winner w. When both are high, w = the pointer; otherwise w = the single requester.
  - s_axi_arready[w] = 1 combinationally in that same cycle; the other bit stays 0.
  - On the clock edge: latch w's AR payload into the m_axi_ar* registers, set m_axi_arvalid = 1, grant = w, state -> ISSUE.
- ISSUE:
  - Hold m_axi_arvalid and the payload stable until m_axi_arready = 1, then clear m_axi_arvalid and go to DATA.
  - s_axi_arready = 0.
- DATA:
  - s_axi_rvalid[grant] = m_axi_rvalid; the other bit = 0.
  - m_axi_rready = s_axi_rready[grant].
  - The R payload is a combinational pass-through.
  - On m_axi_rvalid & m_axi_rready & m_axi_rlast: pointer = ~grant, state -> IDLE.
  - s_axi_arready = 0 throughout.
  - Outside DATA, m_axi_rready = 0 and s_axi_rvalid = 0.
- Latency: AR accepted in cycle N -> m_axi_arvalid high in cycle N+1. R path adds zero cycles.
- Burst lengths: only one burst outstanding at a time. arlen = 0 (single beat) works like any other length; there is no beat counter, and termination uses rlast only.
- Requests during ISSUE/DATA are stalled (arready = 0) and must be held by the master per AXI rules.
- Requester dropping arvalid in IDLE before being accepted: no grant is made; the arbiter re-evaluates on the next cycle.
- Idle-cycle cost: each IDLE pass is at least 1 cycle, so back-to-back bursts have a 1-cycle AR bubble.

Optional Feature:
AXI_RAM_RD_ARB_FIXED_PRIO_EN
- Defined: fixed priority; requester 0 always wins a tie and the pointer is unused (held at 0).
- Undefined (default): round-robin as described above.

Test Plan:
1. s0 requests araddr=0x0100, arlen=3, arid=0x5 alone:
   - m_axi_ar* carries the same values one cycle after the s0 accept;
   - 4 R beats appear on s0 only, with rlast on beat 4;
   - s_axi_rvalid[1] stays 0 throughout.
2. After reset, both requesters hold arvalid continuously (arlen=0) -> grant order s0, s1, s0, s1.
3. During an 8-beat burst to s1, s_axi_rready[1] toggles every cycle:
   - m_axi_rready mirrors it;
   - exactly 8 handshakes occur, with the data sequence intact.
4. m_axi_arready held low for 5 cycles in ISSUE:
   - m_axi_arvalid and the payload stay stable;
   - s_axi_arready stays 2'b00 while s1 holds arvalid.
5. rst driven to 0 mid-burst (beat 2 of 4):
   - m_axi_arvalid, m_axi_rready, s_axi_rvalid and s_axi_arready go to 0 without waiting for a clock edge;
   - after release, the next tie is granted to s0.
6. With AXI_RAM_RD_ARB_FIXED_PRIO_EN defined and both requesters continuously requesting -> s0 granted every time; s1 is granted only when s0's arvalid = 0.
